reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_if.sv | 29 ++
 rtl/reg_file_sb.sv | 105 ++++++++++
 tb/tb_reg_file_sb.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Register-file bus: write port, two read ports, reserve/pending scoreboard and sweep-clear control.
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              rsv;
  logic [ADDR_W-1:0] rsv_addr;
  logic              pend1;
  logic              pend2;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output we, wa, wd, ra1, ra2, rsv, rsv_addr, clr_req,
    input  rd1, rd2, pend1, pend2, clr_busy
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, rsv, rsv_addr, clr_req,
    output rd1, rd2, pend1, pend2, clr_busy
  );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with a pending-bit scoreboard and a one-entry-per-cycle sweep clear.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              busy;

  assign busy         = (state_q == CLEAR);
  assign bus.clr_busy = busy;

  // Sweep sequencer: a clr_req seen mid-sweep is ignored because only IDLE looks at it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Storage update; the reserve is applied after the write so it wins on an address collision.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (busy) begin
      mem_d[ptr_q]  = '0;
      pend_d[ptr_q] = 1'b0;
    end else begin
      if (bus.we) begin
        mem_d[bus.wa]  = bus.wd;
        pend_d[bus.wa] = 1'b0;
      end
      if (bus.rsv) begin
        pend_d[bus.rsv_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      mem_q   <= mem_d;
    end
  end

`ifdef RF_BYPASS_EN
  logic fwd1, fwd2, rsvHit;

  // A forwarded read reports pending only when the same cycle also reserves that register.
  assign fwd1      = bus.we && !busy && (bus.ra1 == bus.wa);
  assign fwd2      = bus.we && !busy && (bus.ra2 == bus.wa);
  assign rsvHit    = bus.rsv && (bus.rsv_addr == bus.wa);
  assign bus.rd1   = fwd1 ? bus.wd : mem_q[bus.ra1];
  assign bus.rd2   = fwd2 ? bus.wd : mem_q[bus.ra2];
  assign bus.pend1 = fwd1 ? rsvHit : pend_q[bus.ra1];
  assign bus.pend2 = fwd2 ? rsvHit : pend_q[bus.ra2];
`else
  assign bus.rd1   = mem_q[bus.ra1];
  assign bus.rd2   = mem_q[bus.ra2];
  assign bus.pend1 = pend_q[bus.ra1];
  assign bus.pend2 = pend_q[bus.ra2];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: an 8x16 instance for the main checks and a 16x32 instance for sizing.
module tb_reg_file_sb;

  logic clk;
  logic rst;
  int   totalChecks;
  int   badChecks;
  int   busyCycles;

`ifdef RF_BYPASS_EN
  localparam logic [15:0] EXP_BYPASS = 16'h00AA;
`else
  localparam logic [15:0] EXP_BYPASS = 16'h0011;
`endif

  reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) busA ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(4)) busB ();

  reg_file_sb #(.DATA_W(16), .ADDR_W(3)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(4)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                               input logic rsv, input logic [2:0] rsvAddr, input logic clrReq);
    busA.we       = we;
    busA.wa       = wa;
    busA.wd       = wd;
    busA.rsv      = rsv;
    busA.rsv_addr = rsvAddr;
    busA.clr_req  = clrReq;
  endtask

  // Inputs change 1ns after the rising edge, well away from the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    busA.ra1 = 3'd0;
    busA.ra2 = 3'd0;
    busB.we = 1'b0; busB.wa = '0; busB.wd = '0; busB.ra1 = '0; busB.ra2 = '0;
    busB.rsv = 1'b0; busB.rsv_addr = '0; busB.clr_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    checkOutput("rstRd1", busA.rd1, 16'h0);
    checkOutput("rstRd2", busA.rd2, 16'h0);
    checkOutput("rstPend1", busA.pend1, 1'b0);
    checkOutput("rstPend2", busA.pend2, 1'b0);
    checkOutput("rstBusy", busA.clr_busy, 1'b0);

    // Write r5 and read it back; every other register stays zero.
    applyStimulus(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    busA.ra1 = 3'd5;
    #1;
    checkOutput("wrR5", busA.rd1, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      if (i != 5) begin
        busA.ra2 = 3'(i);
        #1;
        checkOutput("otherZero", busA.rd2, 16'h0);
      end
    end

    // Reserve, write-clears-pending, and reserve winning over a same-cycle write.
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    busA.ra1 = 3'd3;
    busA.ra2 = 3'd4;
    #1;
    checkOutput("rsvPend", busA.pend1, 1'b1);
    checkOutput("rsvOther", busA.pend2, 1'b0);
    applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    #1;
    checkOutput("wrClrPend", busA.pend1, 1'b0);
    checkOutput("wrBeef", busA.rd1, 16'hBEEF);
    applyStimulus(1'b1, 3'd3, 16'h5555, 1'b1, 3'd3, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    #1;
    checkOutput("rsvWins", busA.pend1, 1'b1);
    checkOutput("rsvWinsData", busA.rd1, 16'h5555);

    // Same-cycle read of the register being written.
    applyStimulus(1'b1, 3'd2, 16'h0011, 1'b0, 3'd0, 1'b0);
    step();
    applyStimulus(1'b1, 3'd2, 16'h00AA, 1'b0, 3'd0, 1'b0);
    busA.ra2 = 3'd2;
    #1;
    checkOutput("bypassRd2", busA.rd2, EXP_BYPASS);
    checkOutput("bypassPend2", busA.pend2, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    #1;
    checkOutput("afterWrRd2", busA.rd2, 16'h00AA);

    // Fill, reserve r1, then sweep; a write and a second clr_req mid-sweep must be dropped.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 16'hFFFF, 1'b0, 3'd0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    busA.ra1 = 3'd1;
    #1;
    checkOutput("fillPend1", busA.pend1, 1'b1);
    checkOutput("fillRd1", busA.rd1, 16'hFFFF);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    busyCycles = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (busA.clr_busy) busyCycles++;
      if (k == 2) begin
        busA.ra1 = 3'd0;
        busA.ra2 = 3'd7;
        #1;
        checkOutput("sweptReadsZero", busA.rd1, 16'h0);
        checkOutput("unsweptReadsOld", busA.rd2, 16'hFFFF);
      end
      if (k == 3) applyStimulus(1'b1, 3'd0, 16'h1234, 1'b1, 3'd0, 1'b0);
      if (k == 4) applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1);
      step();
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    end
    #1;
    checkOutput("sweepCycles", busyCycles, 8);
    checkOutput("sweepDone", busA.clr_busy, 1'b0);
    step();
    checkOutput("noRestart", busA.clr_busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      busA.ra1 = 3'(i);
      #1;
      checkOutput("sweptData", busA.rd1, 16'h0);
      checkOutput("sweptPend", busA.pend1, 1'b0);
    end

    // Reset aborts a sweep at ptr=3.
    applyStimulus(1'b1, 3'd4, 16'h4444, 1'b1, 3'd5, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
    step();
    step();
    step();
    checkOutput("midSweepBusy", busA.clr_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("abortBusy", busA.clr_busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      busA.ra1 = 3'(i);
      #1;
      checkOutput("abortData", busA.rd1, 16'h0);
      checkOutput("abortPend", busA.pend1, 1'b0);
    end
    step();
    checkOutput("abortStays", busA.clr_busy, 1'b0);

    // Wide instance: 16 entries, 32-bit data.
    rst = 1'b1;
    step();
    rst = 1'b0;
    busB.we = 1'b1; busB.wa = 4'd15; busB.wd = 32'hDEADBEEF;
    step();
    busB.we = 1'b0;
    busB.ra1 = 4'd15;
    #1;
    checkOutput("wideR15", busB.rd1, 32'hDEADBEEF);
    busB.clr_req = 1'b1;
    step();
    busB.clr_req = 1'b0;
    #1;
    busyCycles = 0;
    for (int k = 0; k < 40 && busB.clr_busy; k++) begin
      busyCycles++;
      step();
    end
    checkOutput("wideSweepCycles", busyCycles, 16);
    checkOutput("wideSweptR15", busB.rd1, 32'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
